// File: rtl/control_turnos.sv
// Turn sequencer for a 3x3 board: validates moves, detects wins and draws, keeps saturating scores.
// Turn grants and limpia are decoded from the state register; results and the invalid-move flag are registered.
module control_turnos #(
   parameter int MAX_MARCADOR = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] guarda_c1,
   input  logic [1:0] guarda_c2,
   input  logic [1:0] guarda_c3,
   input  logic [1:0] guarda_c4,
   input  logic [1:0] guarda_c5,
   input  logic [1:0] guarda_c6,
   input  logic [1:0] guarda_c7,
   input  logic [1:0] guarda_c8,
   input  logic [1:0] guarda_c9,
   input  logic       boton_reinicio,
   output logic       turno_p1,
   output logic       turno_p2,
   output logic       limpia,
   output logic       gana_p1,
   output logic       gana_p2,
   output logic       empate,
   output logic [3:0] linea_ganadora,
   output logic [3:0] marcador_p1,
   output logic [3:0] marcador_p2,
   output logic       jugada_invalida
);
   typedef enum logic [2:0] {INICIO, TURNO_P1, TURNO_P2, EVALUA, FIN} estado_t;
   localparam logic [3:0] MAX_M = 4'(MAX_MARCADOR);

   estado_t         r_estado, w_estado_sig;
   logic [8:0][1:0] r_snap;
   logic [8:0][1:0] w_tablero;
   logic            r_inicia_p1, r_mueve_p1, r_boton_ant;
   logic            r_gana_p1, r_gana_p2, r_empate, r_inval;
   logic [3:0]      r_linea, r_marc_p1, r_marc_p2;
   logic            w_flanco, w_en_turno, w_vacio, w_lleno, w_hay_dif, w_mov_malo, w_mov_valido;
   logic [1:0]      w_cod_turno, w_cod_eval;
   logic [3:0]      w_n_dif, w_linea;

   assign w_tablero   = {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                         guarda_c4, guarda_c3, guarda_c2, guarda_c1};
   assign w_flanco    = boton_reinicio & ~r_boton_ant;
   assign w_en_turno  = (r_estado == TURNO_P1) || (r_estado == TURNO_P2);
   assign w_vacio     = (w_tablero == '0);
   assign w_cod_turno = (r_estado == TURNO_P1) ? 2'b11 : 2'b01;
   assign w_cod_eval  = r_mueve_p1 ? 2'b11 : 2'b01;

   // Checked from code 8 down to 1 so the lowest winning code is the one kept.
   function automatic logic [3:0] linea_de(input logic [8:0][1:0] s, input logic [1:0] c);
      logic [3:0] l;
      l = 4'd0;
      if (s[2] == c && s[4] == c && s[6] == c) l = 4'd8;
      if (s[0] == c && s[4] == c && s[8] == c) l = 4'd7;
      if (s[2] == c && s[5] == c && s[8] == c) l = 4'd6;
      if (s[1] == c && s[4] == c && s[7] == c) l = 4'd5;
      if (s[0] == c && s[3] == c && s[6] == c) l = 4'd4;
      if (s[6] == c && s[7] == c && s[8] == c) l = 4'd3;
      if (s[3] == c && s[4] == c && s[5] == c) l = 4'd2;
      if (s[0] == c && s[1] == c && s[2] == c) l = 4'd1;
      return l;
   endfunction

   always_comb begin
      w_n_dif    = 4'd0;
      w_mov_malo = 1'b0;
      w_lleno    = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (w_tablero[i] != r_snap[i]) begin
            w_n_dif = w_n_dif + 4'd1;
            if (r_snap[i] != 2'b00 || w_tablero[i] != w_cod_turno) w_mov_malo = 1'b1;
         end
         if (r_snap[i] == 2'b00) w_lleno = 1'b0;
      end
   end

   assign w_hay_dif    = (w_n_dif != 4'd0);
   assign w_mov_valido = w_en_turno && (w_n_dif == 4'd1) && !w_mov_malo;
   assign w_linea      = linea_de(r_snap, w_cod_eval);

   always_comb begin
      w_estado_sig = r_estado;
      case (r_estado)
         INICIO:             if (w_vacio) w_estado_sig = r_inicia_p1 ? TURNO_P1 : TURNO_P2;
         TURNO_P1, TURNO_P2: if (w_mov_valido) w_estado_sig = EVALUA;
         EVALUA: begin
            if (w_linea != 4'd0 || w_lleno) w_estado_sig = FIN;
            else                            w_estado_sig = r_mueve_p1 ? TURNO_P2 : TURNO_P1;
         end
         FIN:                if (w_flanco) w_estado_sig = INICIO;
         default:            w_estado_sig = INICIO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_estado    <= INICIO;
         r_snap      <= '0;
         r_inicia_p1 <= 1'b1;
         r_mueve_p1  <= 1'b0;
         r_boton_ant <= 1'b0;
         r_gana_p1   <= 1'b0;
         r_gana_p2   <= 1'b0;
         r_empate    <= 1'b0;
         r_linea     <= 4'd0;
         r_marc_p1   <= 4'd0;
         r_marc_p2   <= 4'd0;
         r_inval     <= 1'b0;
      end else begin
         r_estado    <= w_estado_sig;
         r_boton_ant <= boton_reinicio;
         r_inval     <= w_en_turno && w_hay_dif && !w_mov_valido;
         case (r_estado)
            INICIO: if (w_vacio) r_snap <= '0;
            TURNO_P1, TURNO_P2: begin
               if (w_mov_valido) begin
                  r_snap     <= w_tablero;
                  r_mueve_p1 <= (r_estado == TURNO_P1);
               end
            end
            EVALUA: begin
               if (w_linea != 4'd0) begin
                  r_linea <= w_linea;
                  if (r_mueve_p1) begin
                     r_gana_p1 <= 1'b1;
                     if (r_marc_p1 != MAX_M) r_marc_p1 <= r_marc_p1 + 4'd1;
                  end else begin
                     r_gana_p2 <= 1'b1;
                     if (r_marc_p2 != MAX_M) r_marc_p2 <= r_marc_p2 + 4'd1;
                  end
               end else if (w_lleno) begin
                  r_empate <= 1'b1;
               end
            end
            FIN: begin
               if (w_flanco) begin
                  r_inicia_p1 <= ~r_inicia_p1;
                  r_gana_p1   <= 1'b0;
                  r_gana_p2   <= 1'b0;
                  r_empate    <= 1'b0;
                  r_linea     <= 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign turno_p1        = (r_estado == TURNO_P1);
   assign turno_p2        = (r_estado == TURNO_P2);
   assign limpia          = (r_estado == INICIO);
   assign gana_p1         = r_gana_p1;
   assign gana_p2         = r_gana_p2;
   assign empate          = r_empate;
   assign linea_ganadora  = r_linea;
   assign marcador_p1     = r_marc_p1;
   assign marcador_p2     = r_marc_p2;
   assign jugada_invalida = r_inval;
endmodule

// File: doc/control_turnos.md
CONTROL_TURNOS -- requirements
Module: control_turnos

Interface
REQ-001 Parameter: MAX_MARCADOR, default 9, saturation value of each score counter (1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 guarda_c1..guarda_c9  input  2 each  board cells from the square selector; 00 empty, 11 player 1, 01 player 2; cell numbering 1-2-3 / 4-5-6 / 7-8-9 by row.
REQ-005 boton_reinicio  input  1  new-game request, level; internally rising-edge detected.
REQ-006 turno_p1, turno_p2  output  1 each  registered turn grant to the square selector.
REQ-007 limpia  output  1  request to clear the board, asserted while in INICIO.
REQ-008 gana_p1, gana_p2, empate  output  1 each  registered game result, held in FIN.
REQ-009 linea_ganadora  output  4  winning line code 1..8, 0 if none.
REQ-010 marcador_p1, marcador_p2  output  4 each  games won per player.
REQ-011 jugada_invalida  output  1  level flag, illegal board change detected.

Function
REQ-012 The FSM SHALL have states INICIO, TURNO_P1, TURNO_P2, EVALUA, FIN.
REQ-013 The block SHALL hold a registered snapshot of the nine cells and a 1-bit inicia_p1 register.
REQ-014 INICIO: limpia=1; when all nine inputs equal 00, snapshot SHALL be cleared and the next state SHALL be TURNO_P1 if inicia_p1=1, else TURNO_P2.
REQ-015 turno_p1 SHALL be 1 exactly in TURNO_P1 and turno_p2 exactly in TURNO_P2; both SHALL be 0 in all other states.
REQ-016 In TURNO_Px, a valid move is one previously empty snapshot cell now equal to the mover's code (11 for P1, 01 for P2), with all other cells unchanged.
REQ-017 A valid move seen at edge N SHALL update the snapshot and enter EVALUA at N+1 (turn outputs 0 from N+1).
REQ-018 Any other difference between board and snapshot in TURNO_Px SHALL assert jugada_invalida while it persists; the state and snapshot SHALL NOT change.
REQ-019 Line codes: 1=c1c2c3, 2=c4c5c6, 3=c7c8c9, 4=c1c4c7, 5=c2c5c8, 6=c3c6c9, 7=c1c5c9, 8=c3c5c7; a line is won when all three snapshot cells equal the mover's code.
REQ-020 EVALUA (one cycle): if the mover owns any line, the next state SHALL be FIN with gana_px=1 and linea_ganadora = the lowest winning code; the mover's score SHALL increment unless it already equals MAX_MARCADOR.
REQ-021 EVALUA: else if all nine cells are non-zero, the next state SHALL be FIN with empate=1 and linea_ganadora=0.
REQ-022 EVALUA: otherwise the next state SHALL be the opposite player's TURNO state (move at N -> new turn grant at N+2).
REQ-023 The win check SHALL take priority over the draw check when the ninth move completes a line.
REQ-024 FIN: results SHALL be held, turn outputs stay 0, and board changes SHALL be ignored.
REQ-025 On a boton_reinicio rising edge in FIN: inicia_p1 SHALL toggle, results and linea_ganadora SHALL clear, and the next state SHALL be INICIO.
REQ-026 Outside FIN, boton_reinicio edges SHALL be ignored.
REQ-027 Scores SHALL be preserved across games and saturate at MAX_MARCADOR.

Reset
REQ-028 When reset=1 at a rising edge, the block SHALL enter INICIO.
REQ-029 On reset: snapshot=0, inicia_p1=1, scores=0, all result, turn and flag outputs 0, and the edge-detector history cleared.
REQ-030 Reset SHALL take priority over every other input, including mid-game and coincident boton_reinicio.

Verification
REQ-031 Reset with empty board -> limpia=1 for 1 cycle, then turno_p1=1, turno_p2=0.
REQ-032 P1 moves c1, c2, c3 with P2 moves c4, c5 in between -> gana_p1=1, linea_ganadora=1, marcador_p1=1, both turn outputs 0.
REQ-033 During TURNO_P2, c5 changes 11->01 -> jugada_invalida=1, state stays TURNO_P2, and there is no turn change.
REQ-034 Nine moves with no line (X:1,3,4,8,9 / O:2,5,6,7 pattern) -> empate=1, linea_ganadora=0, scores unchanged.
REQ-035 Reinicio in FIN while the board is non-empty -> INICIO is held with limpia=1 until cleared, then turno_p2=1 (inicia_p1 toggled).
REQ-036 Ten P1 wins with MAX_MARCADOR=9 -> marcador_p1 stays 9; reset mid-TURNO_P2 -> INICIO with scores 0.
